ieee_mult_pipe: RTL and testbench
=================================

// Module: ieee_mult_pipe
// PURPOSE
//  Pipelined, width-parametrised IEEE-754-style floating-point multiplier for the CNN MAC datapath.
//  Successor to the combinational FP16 multiplier:
//   - registered 3-stage pipeline with valid/ready handshake and backpressure
//   - correct single-step normalisation, overflow to infinity, underflow flush to zero
//   - Inf/NaN handling
//  Sits between the weight/activation fetch stage and the accumulator adder.
// PARAMETERS
//  EXP_W  5   exponent field width (bits)
//  MAN_W  10  stored mantissa width (bits); word width W = 1+EXP_W+MAN_W (default 16, FP16)
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   synchronous, active-high reset
//  in_valid   in   1   operand pair valid
//  in_ready   out  1   block can accept operands this cycle
//  floatA     in   W   operand A {sign, exp, mantissa}
//  floatB     in   W   operand B
//  out_valid  out  1   product valid
//  out_ready  in   1   downstream accepts product
//  product    out  W   result {sign, exp, mantissa}
//  busy       out  1   any pipeline stage holds a valid entry
// BEHAVIOUR
//  - Reset: all stage valid bits = 0; out_valid=0, product=0, busy=0; in_ready=1 the cycle after reset drops.
//  - Reset mid-operation: all in-flight operations are discarded with no output; no partial result is ever presented.
//  - Pipeline advance: adv = ~out_valid | out_ready (global stall); in_ready = adv (combinational).
//  - Transfer occurs when in_valid & in_ready. Latency is 3 cycles from accept to out_valid with no stall.
//  - Throughput is 1/cycle. product is held stable while out_valid & ~out_ready.
//  - Stage 1, unpack/classify:
//      sign = A.s ^ B.s.
//      BIAS = 2^(EXP_W-1)-1. expsum = eA + eB - BIAS, signed, EXP_W+2 bits.
//      Flags: zero (exp==0, denormals flushed to zero), inf (exp all-ones, man==0), nan (exp all-ones, man!=0).
//  - Stage 2, multiply: P = {1,mA} * {1,mB}, 2*MAN_W+2 bits, unsigned.
//  - Stage 3, normalise/round/pack:
//      If P[MSB]=1, shift right 1 and expsum+1 (at most one shift).
//      Mantissa is the MAN_W bits below the leading 1; guard = next bit; sticky = OR of the rest.
//  - Special-case priority, highest first:
//      1. nan, or zero*inf           -> canonical NaN {0, all-ones, 1,0..0}
//      2. inf                        -> {sign, all-ones, 0}
//      3. zero                       -> {sign, 0, 0}
//      4. final exp >= 2^EXP_W-1     -> {sign, all-ones, 0} (overflow)
//      5. final exp <= 0             -> {sign, 0, 0} (underflow flush)
//      6. otherwise                  -> {sign, exp[EXP_W-1:0], mantissa}
//  - busy = OR of stage valid bits.
// CONFIGURATION
//  IEEE_MULT_ROUND_EN defined:
//   - round-to-nearest-even: increment when guard & (sticky | lsb).
//   - Mantissa carry-out renormalises with exp+1; overflow is re-checked after rounding.
//  IEEE_MULT_ROUND_EN undefined:
//   - truncate (round toward zero); guard and sticky are ignored.
//  Latency and handshake are identical in both builds.
// STRUCTURE
//  Package ieee_fp_pkg holds:
//   - BIAS, EXP_MAX and canonical-NaN constants as functions of EXP_W/MAN_W
//   - an fp_class_t enum {ZERO, NORM, INF, NAN}
//   - an unpacked-operand struct {sign, exp, man, class}
//  One natural sub-module: ieee_fp_normround (stage-3 normalise/round/pack logic).
//  Classify logic is reused by the planned adder.
// TESTING (FP16 default; out_ready=1 unless stated)
//  1. 0x3C00*0x3C00 -> 0x3C00; 0x3E00*0x4000 -> 0x4200; 0xC000*0x4200 -> 0xC600; each out_valid exactly 3 cycles after accept.
//  2. 0x7BFF*0x7BFF -> 0x7C00 (overflow); 0x0400*0x0400 -> 0x0000 (underflow); 0x8000*0x3C00 -> 0x8000.
//  3. 0x0000*0x7C00 -> 0x7E00; 0x7C01*0x3C00 -> 0x7E00; 0xFC00*0x4000 -> 0xFC00.
//  4. 0x3E01*0x3C01: ROUND_EN -> 0x3E03; without -> 0x3E02.
//  5. Back-to-back stream of 8 pairs with out_ready low for cycles 4-6:
//      - in_ready drops while stalled; product is held
//      - all 8 results arrive in order, none lost or duplicated
//  6. reset asserted with 3 ops in flight -> next cycle out_valid=0, busy=0; no stale product appears after reset drops.

Source files
------------

// File: rtl/ieee_fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ieee_fp_pkg
// Description : Shared IEEE-754-style format helpers: bias, exponent limits,
//               canonical NaN, operand classification and unpacked operand.
// Revision    : 1.0 - initial release
// ============================================================================
package ieee_fp_pkg;

    localparam int FP_EXP_W = 5;
    localparam int FP_MAN_W = 10;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_t;

    // Unpacked operand at the default (FP16) field widths
    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W-1:0] man;
        fp_class_t           cls;
    } fp_unpacked_t;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fp_exp_max(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        return (64'(fp_exp_max(exp_w)) << man_w) | (64'd1 << (man_w - 1));
    endfunction

    // Denormals (exp==0) are treated as zero
    function automatic fp_class_t fp_classify(input logic exp_zero,
                                              input logic exp_ones,
                                              input logic man_nz);
        if (exp_zero)
            return ZERO;
        if (!exp_ones)
            return NORM;
        return man_nz ? NAN : INF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ieee_fp_normround.sv
`default_nettype none
// ============================================================================
// Module      : ieee_fp_normround
// Description : Normalise, round/truncate and pack a raw mantissa product,
//               applying special-case priority. Rounding mode selected by
//               macro IEEE_MULT_ROUND_EN (defined: RNE, undefined: truncate).
// Revision    : 1.0 - initial release
// ============================================================================
module ieee_fp_normround
    import ieee_fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic                     i_sign,
    input  logic signed [EXP_W+1:0]  i_expsum,
    input  logic [2*MAN_W+1:0]       i_prod,
    input  logic                     i_nan,
    input  logic                     i_inf,
    input  logic                     i_zero,
    output logic [EXP_W+MAN_W:0]     o_word
);

    localparam int c_PW = 2*MAN_W + 2;
    localparam int c_SW = EXP_W + 2;
    localparam logic signed [c_SW-1:0]    c_EXP_ALL  = c_SW'(fp_exp_max(EXP_W));
    localparam logic signed [c_SW-1:0]    c_EXP_ZERO = '0;
    localparam logic [EXP_W+MAN_W:0]      c_QNAN     = (EXP_W+MAN_W+1)'(fp_qnan(EXP_W, MAN_W));

    logic [c_PW-2:0]          w_norm;
    logic [MAN_W-1:0]         w_man;
    logic [MAN_W-1:0]         w_man_f;
    logic                     w_guard;
    logic                     w_sticky;
    logic signed [c_SW-1:0]   w_exp_n;
    logic signed [c_SW-1:0]   w_exp_f;

    // Leading one sits at bit PW-1 or PW-2; align it just above w_norm
    always_comb begin
        w_norm   = i_prod[c_PW-1] ? i_prod[c_PW-2:0] : {i_prod[c_PW-3:0], 1'b0};
        w_exp_n  = i_expsum + $signed({{(c_SW-1){1'b0}}, i_prod[c_PW-1]});
        w_man    = w_norm[c_PW-2 -: MAN_W];
        w_guard  = w_norm[MAN_W];
        w_sticky = |w_norm[MAN_W-1:0];
    end

`ifdef IEEE_MULT_ROUND_EN
    logic [MAN_W:0] w_man_r;
    // Carry-out leaves the low bits zero, i.e. mantissa 1.0 at exp+1
    always_comb begin
        w_man_r = {1'b0, w_man} + {{MAN_W{1'b0}}, w_guard & (w_sticky | w_man[0])};
        w_man_f = w_man_r[MAN_W-1:0];
        w_exp_f = w_exp_n + $signed({{(c_SW-1){1'b0}}, w_man_r[MAN_W]});
    end
`else
    logic w_unused_round;
    always_comb begin
        w_man_f        = w_man;
        w_exp_f        = w_exp_n;
        w_unused_round = w_guard ^ w_sticky;
    end
`endif

    always_comb begin
        if (i_nan)
            o_word = c_QNAN;
        else if (i_inf)
            o_word = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (i_zero)
            o_word = {i_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
        else if (w_exp_f >= c_EXP_ALL)
            o_word = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (w_exp_f <= c_EXP_ZERO)
            o_word = {i_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
        else
            o_word = {i_sign, w_exp_f[EXP_W-1:0], w_man_f};
    end

endmodule
`default_nettype wire

// File: rtl/ieee_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ieee_mult_pipe
// Description : 3-stage pipelined floating-point multiplier with valid/ready
//               handshake and global stall. Optional RNE rounding via macro
//               IEEE_MULT_ROUND_EN (default build truncates).
// Revision    : 1.0 - initial release
// ============================================================================
module ieee_mult_pipe
    import ieee_fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_W+MAN_W:0]  floatA,
    input  logic [EXP_W+MAN_W:0]  floatB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+MAN_W:0]  product,
    output logic                  busy
);

    localparam int c_SW = EXP_W + 2;
    localparam int c_PW = 2*MAN_W + 2;
    localparam logic signed [c_SW-1:0] c_BIAS = c_SW'(fp_bias(EXP_W));

    logic                   w_adv;
    logic [EXP_W-1:0]       w_a_exp, w_b_exp;
    logic [MAN_W-1:0]       w_a_man, w_b_man;
    fp_class_t              w_a_cls, w_b_cls;
    logic [EXP_W+MAN_W:0]   w_word;

    logic                   r_v1_q, r_v2_q, r_v3_q;
    logic                   w_v1_d, w_v2_d, w_v3_d;

    logic                   r_sign1_q, w_sign1_d;
    logic signed [c_SW-1:0] r_exp1_q, w_exp1_d;
    logic [MAN_W:0]         r_mana1_q, w_mana1_d;
    logic [MAN_W:0]         r_manb1_q, w_manb1_d;
    logic                   r_nan1_q, w_nan1_d;
    logic                   r_inf1_q, w_inf1_d;
    logic                   r_zero1_q, w_zero1_d;

    logic                   r_sign2_q, w_sign2_d;
    logic signed [c_SW-1:0] r_exp2_q, w_exp2_d;
    logic [c_PW-1:0]        r_prod2_q, w_prod2_d;
    logic                   r_nan2_q, w_nan2_d;
    logic                   r_inf2_q, w_inf2_d;
    logic                   r_zero2_q, w_zero2_d;

    logic [EXP_W+MAN_W:0]   r_prod_q, w_prod_d;

    always_comb begin
        w_a_exp = floatA[MAN_W +: EXP_W];
        w_b_exp = floatB[MAN_W +: EXP_W];
        w_a_man = floatA[MAN_W-1:0];
        w_b_man = floatB[MAN_W-1:0];
        w_a_cls = fp_classify(w_a_exp == '0, &w_a_exp, |w_a_man);
        w_b_cls = fp_classify(w_b_exp == '0, &w_b_exp, |w_b_man);
    end

    // Every stage moves together; a held output freezes the whole pipe
    always_comb begin
        w_adv = ~r_v3_q | out_ready;

        w_v1_d = r_v1_q;
        w_v2_d = r_v2_q;
        w_v3_d = r_v3_q;
        if (w_adv) begin
            w_v1_d = in_valid;
            w_v2_d = r_v1_q;
            w_v3_d = r_v2_q;
        end

        w_sign1_d = r_sign1_q;
        w_exp1_d  = r_exp1_q;
        w_mana1_d = r_mana1_q;
        w_manb1_d = r_manb1_q;
        w_nan1_d  = r_nan1_q;
        w_inf1_d  = r_inf1_q;
        w_zero1_d = r_zero1_q;
        if (w_adv && in_valid) begin
            w_sign1_d = floatA[EXP_W+MAN_W] ^ floatB[EXP_W+MAN_W];
            w_exp1_d  = $signed({2'b00, w_a_exp}) + $signed({2'b00, w_b_exp}) - c_BIAS;
            w_mana1_d = {1'b1, w_a_man};
            w_manb1_d = {1'b1, w_b_man};
            w_nan1_d  = (w_a_cls == NAN) || (w_b_cls == NAN)
                      || (w_a_cls == ZERO && w_b_cls == INF)
                      || (w_a_cls == INF && w_b_cls == ZERO);
            w_inf1_d  = (w_a_cls == INF) || (w_b_cls == INF);
            w_zero1_d = (w_a_cls == ZERO) || (w_b_cls == ZERO);
        end

        w_sign2_d = r_sign2_q;
        w_exp2_d  = r_exp2_q;
        w_prod2_d = r_prod2_q;
        w_nan2_d  = r_nan2_q;
        w_inf2_d  = r_inf2_q;
        w_zero2_d = r_zero2_q;
        if (w_adv && r_v1_q) begin
            w_sign2_d = r_sign1_q;
            w_exp2_d  = r_exp1_q;
            w_prod2_d = c_PW'(r_mana1_q) * c_PW'(r_manb1_q);
            w_nan2_d  = r_nan1_q;
            w_inf2_d  = r_inf1_q;
            w_zero2_d = r_zero1_q;
        end

        w_prod_d = r_prod_q;
        if (w_adv && r_v2_q)
            w_prod_d = w_word;
    end

    ieee_fp_normround #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_normround (
        .i_sign   (r_sign2_q),
        .i_expsum (r_exp2_q),
        .i_prod   (r_prod2_q),
        .i_nan    (r_nan2_q),
        .i_inf    (r_inf2_q),
        .i_zero   (r_zero2_q),
        .o_word   (w_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1_q   <= 1'b0;
            r_v2_q   <= 1'b0;
            r_v3_q   <= 1'b0;
            r_prod_q <= '0;
        end else begin
            r_v1_q   <= w_v1_d;
            r_v2_q   <= w_v2_d;
            r_v3_q   <= w_v3_d;
            r_prod_q <= w_prod_d;
        end
    end

    always_ff @(posedge clk) begin
        r_sign1_q <= w_sign1_d;
        r_exp1_q  <= w_exp1_d;
        r_mana1_q <= w_mana1_d;
        r_manb1_q <= w_manb1_d;
        r_nan1_q  <= w_nan1_d;
        r_inf1_q  <= w_inf1_d;
        r_zero1_q <= w_zero1_d;
        r_sign2_q <= w_sign2_d;
        r_exp2_q  <= w_exp2_d;
        r_prod2_q <= w_prod2_d;
        r_nan2_q  <= w_nan2_d;
        r_inf2_q  <= w_inf2_d;
        r_zero2_q <= w_zero2_d;
    end

    always_comb begin
        in_ready  = w_adv;
        out_valid = r_v3_q;
        product   = r_prod_q;
        busy      = r_v1_q | r_v2_q | r_v3_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_ieee_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ieee_mult_pipe
// Description : Scoreboard bench for ieee_mult_pipe (FP16), directed vectors.
//               Honors IEEE_MULT_ROUND_EN for the rounding vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ieee_mult_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] floatA = '0;
    logic [15:0] floatB = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] product;
    logic        busy;

    always #5 clk = ~clk;

    ieee_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .floatA    (floatA),
        .floatB    (floatB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    typedef struct {
        logic [15:0] exp;
        int          acc;
        bit          lat;
    } sb_t;

    sb_t sbq[$];
    int  tests = 0, fails = 0, cyc = 0, n_pushed = 0, n_recv = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Directed vectors: a, b, expected
    logic [15:0] v_a[10] = '{16'h3C00, 16'h3E00, 16'hC000, 16'h7BFF, 16'h0400,
                             16'h8000, 16'h0000, 16'h7C01, 16'hFC00, 16'h3E01};
    logic [15:0] v_b[10] = '{16'h3C00, 16'h4000, 16'h4200, 16'h7BFF, 16'h0400,
                             16'h3C00, 16'h7C00, 16'h3C00, 16'h4000, 16'h3C01};
`ifdef IEEE_MULT_ROUND_EN
    logic [15:0] v_e[10] = '{16'h3C00, 16'h4200, 16'hC600, 16'h7C00, 16'h0000,
                             16'h8000, 16'h7E00, 16'h7E00, 16'hFC00, 16'h3E03};
`else
    logic [15:0] v_e[10] = '{16'h3C00, 16'h4200, 16'hC600, 16'h7C00, 16'h0000,
                             16'h8000, 16'h7E00, 16'h7E00, 16'hFC00, 16'h3E02};
`endif
    // Stream: each a times 2.0
    logic [15:0] s_a[8] = '{16'h3C00, 16'h3E00, 16'h4000, 16'h4200,
                            16'h4400, 16'h4500, 16'h4600, 16'h4700};
    logic [15:0] s_e[8] = '{16'h4000, 16'h4200, 16'h4400, 16'h4600,
                            16'h4800, 16'h4900, 16'h4A00, 16'h4B00};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input logic [15:0] e, input bit lat);
        sb_t s;
        s.exp = e;
        s.acc = cyc;
        s.lat = lat;
        sbq.push_back(s);
        n_pushed++;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] e, input bit lat, input bit score);
        int waitc;
        waitc = 0;
        @(negedge clk); #1;
        floatA   = a;
        floatB   = b;
        in_valid = 1'b1;
        #1;
        while (!in_ready && waitc < 50) begin
            @(negedge clk); #2;
            waitc++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready stayed %b, expected 1", in_ready);
        end else if (score) begin
            push(e, lat);
        end
    endtask

    task automatic idle();
        @(negedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Monitor: pops on every output transfer, checks hold during stalls
    initial begin : mon
        logic [15:0] held;
        bit          hold_v;
        sb_t         e;
        hold_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk); #3;
            if (reset) begin
                hold_v = 1'b0;
                continue;
            end
            if (hold_v) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_product", 32'(product), 32'(held));
            end
            hold_v = 1'b0;
            if (out_valid && !out_ready) begin
                held   = product;
                hold_v = 1'b1;
            end
            if (out_valid && out_ready) begin
                n_recv++;
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: product %h, expected no output", product);
                end else begin
                    e = sbq.pop_front();
                    chk("product", 32'(product), 32'(e.exp));
                    if (e.lat)
                        chk("latency", 32'(cyc - e.acc), 32'd3);
                end
            end
        end
    end

    initial begin : drv
        int idx;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_product", 32'(product), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Basic, overflow/underflow, specials, rounding
        for (int i = 0; i < 10; i++)
            send(v_a[i], v_b[i], v_e[i], 1'b1, 1'b1);
        idle();
        repeat (6) @(negedge clk);

        // Back-to-back stream with a 3-cycle downstream stall
        idx = 0;
        for (int k = 0; k < 60 && idx < 8; k++) begin
            @(negedge clk); #1;
            out_ready = !(k >= 4 && k <= 6);
            floatA    = s_a[idx];
            floatB    = 16'h4000;
            in_valid  = 1'b1;
            #1;
            if (k >= 4 && k <= 6)
                chk("stall_in_ready", 32'(in_ready), 32'd0);
            if (in_ready) begin
                push(s_e[idx], 1'b0);
                idx++;
            end
        end
        @(negedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && sbq.size() != 0; i++)
            @(negedge clk);
        chk("drain_empty", 32'(sbq.size()), 32'd0);

        // Reset with three operations in flight
        @(negedge clk); #1;
        out_ready = 1'b0;
        send(16'h3C00, 16'h3C00, 16'h0, 1'b0, 1'b0);
        send(16'h4000, 16'h4000, 16'h0, 1'b0, 1'b0);
        send(16'h4200, 16'h4200, 16'h0, 1'b0, 1'b0);
        @(negedge clk); #1;
        in_valid = 1'b0;
        reset    = 1'b1;
        chk("busy_in_flight", 32'(busy), 32'd1);
        @(negedge clk); #2;
        chk("mid_reset_out_valid", 32'(out_valid), 32'd0);
        chk("mid_reset_busy", 32'(busy), 32'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_reset_busy", 32'(busy), 32'd0);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        chk("recv_count", 32'(n_recv), 32'(n_pushed));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
